// File: rtl/hdb3_pkg.sv
// hdb3_pkg
// Shared types for the HDB3 receive-path clock recovery:
//   level_t - ternary slicer level (0, +1, -1)
//   state_t - clock recovery FSM state
package hdb3_pkg;

    typedef enum logic [1:0] {
        LVL_ZERO = 2'b00,
        LVL_POS  = 2'b01,
        LVL_NEG  = 2'b10
    } level_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10
    } state_t;

endpackage

// File: rtl/hdb3_level_slicer.sv
// hdb3_level_slicer
// Registered ternary slicer for oversampled ADC words. Samples that fall in
// none of the three bands (the hold band) keep the previous level.
// Ports:
//   i_clk    - sample clock, rising edge
//   i_rst    - synchronous active-high reset (level -> LVL_ZERO)
//   i_data   - ADC sample, unsigned
//   o_level  - registered level, one cycle after i_data
module hdb3_level_slicer
    import hdb3_pkg::*;
#(
    parameter int unsigned    DW      = 8,
    parameter logic [DW-1:0]  POS_TH  = DW'(8'h58),
    parameter logic [DW-1:0]  ZERO_LO = DW'(8'h30),
    parameter logic [DW-1:0]  ZERO_HI = DW'(8'h3F),
    parameter logic [DW-1:0]  NEG_TH  = DW'(8'h0F)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_data,
    output level_t        o_level
);

    level_t r_level;
    level_t w_level_d;

    always_comb begin
        w_level_d = r_level;
        if (i_data >= POS_TH) begin
            w_level_d = LVL_POS;
        end else if ((i_data >= ZERO_LO) && (i_data <= ZERO_HI)) begin
            w_level_d = LVL_ZERO;
        end else if (i_data <= NEG_TH) begin
            w_level_d = LVL_NEG;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= LVL_ZERO;
        end else begin
            r_level <= w_level_d;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/hdb3_clk_recover.sv
// hdb3_clk_recover
// Symbol clock and data recovery for the HDB3 receive path. Slices ADC words
// into ternary levels, detects level transitions and aligns a modulo-OSR
// phase counter to them.
// Ports:
//   clk_in    - ADC sample clock, rising edge
//   rst       - synchronous active-high reset
//   indata    - ADC sample
//   clk_out   - recovered 50 % duty symbol clock (high for ph >= OSR/2)
//   sym_valid - one-cycle strobe at mid-bit (ph == OSR/2)
//   sym       - ternary symbol valid with sym_valid (00 = 0, 01 = +1, 10 = -1)
//   locked    - high while the FSM is LOCKED
// Build option: define CLK_RECOVER_NUDGE_EN to make LOCKED-state edges pull
// the phase by one count instead of hard-realigning it.
module hdb3_clk_recover
    import hdb3_pkg::*;
#(
    parameter int unsigned    DW        = 8,
    parameter int unsigned    OSR       = 16,
    parameter logic [DW-1:0]  POS_TH    = DW'(8'h58),
    parameter logic [DW-1:0]  ZERO_LO   = DW'(8'h30),
    parameter logic [DW-1:0]  ZERO_HI   = DW'(8'h3F),
    parameter logic [DW-1:0]  NEG_TH    = DW'(8'h0F),
    parameter int unsigned    TOL       = 1,
    parameter int unsigned    LOCK_CNT  = 8,
    parameter int unsigned    LOSS_BITS = 6
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic [DW-1:0] indata,
    output logic          clk_out,
    output logic          sym_valid,
    output logic [1:0]    sym,
    output logic          locked
);

    localparam int unsigned     PH_W    = $clog2(OSR);
    localparam int unsigned     OK_W    = $clog2(LOCK_CNT + 1);
    localparam int unsigned     SIL_W   = $clog2(LOSS_BITS + 1);
    localparam logic [PH_W-1:0] PH_MAX  = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(OSR / 2);
    localparam logic [SIL_W-1:0] SIL_MAX = SIL_W'(LOSS_BITS);

    level_t           w_level;
    level_t           r_level_prev;
    state_t           r_state, w_state_d;
    logic [PH_W-1:0]  r_ph, w_ph_d;
    logic [OK_W-1:0]  r_ok_cnt, w_ok_d;
    logic [SIL_W-1:0] r_silence_cnt, w_sil_d;
    logic             r_clk_out, r_sym_valid, r_locked;
    level_t           r_sym;

    logic             w_edge, w_wrap, w_on_time, w_strobe_d;
    logic [31:0]      w_ph_u, w_err;

    hdb3_level_slicer #(
        .DW      (DW),
        .POS_TH  (POS_TH),
        .ZERO_LO (ZERO_LO),
        .ZERO_HI (ZERO_HI),
        .NEG_TH  (NEG_TH)
    ) u_slicer (
        .i_clk   (clk_in),
        .i_rst   (rst),
        .i_data  (indata),
        .o_level (w_level)
    );

    assign w_edge    = (w_level != r_level_prev);
    assign w_wrap    = (r_state != IDLE) && (r_ph == PH_MAX);
    assign w_ph_u    = 32'(r_ph);
    // Distance of the edge from phase 0, measured both ways round the circle.
    assign w_err     = (w_ph_u <= OSR / 2) ? w_ph_u : (OSR - w_ph_u);
    assign w_on_time = (w_ph_u <= TOL) || (w_ph_u >= OSR - TOL);

    always_comb begin
        w_state_d = r_state;
        w_ph_d    = r_ph;
        w_ok_d    = r_ok_cnt;
        w_sil_d   = r_silence_cnt;

        if (r_state != IDLE) begin
            w_ph_d = (r_ph == PH_MAX) ? '0 : r_ph + PH_W'(1);
        end

        // An edge beats a simultaneous wrap.
        if (w_edge) begin
            w_sil_d = '0;
        end else if (w_wrap && (r_silence_cnt != SIL_MAX)) begin
            w_sil_d = r_silence_cnt + SIL_W'(1);
        end

        unique case (r_state)
            IDLE: begin
                if (w_edge) begin
                    // The acquiring edge sits at phase 0, so it is the first
                    // on-time edge.
                    w_ph_d    = '0;
                    w_ok_d    = OK_W'(1);
                    w_state_d = (LOCK_CNT <= 1) ? LOCKED : ACQ;
                end
            end
            ACQ: begin
                if (w_edge) begin
                    w_ph_d = '0;
                    if (w_on_time) begin
                        if (32'(r_ok_cnt) + 32'd1 >= LOCK_CNT) begin
                            w_state_d = LOCKED;
                            w_ok_d    = '0;
                        end else begin
                            w_ok_d = r_ok_cnt + OK_W'(1);
                        end
                    end else begin
                        w_ok_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (w_edge) begin
                    if (w_err > OSR / 4) begin
                        w_state_d = ACQ;
                        w_ph_d    = '0;
                        w_ok_d    = '0;
                    end else begin
`ifdef CLK_RECOVER_NUDGE_EN
                        // ph == 0 keeps the normal increment.
                        if (r_ph != '0) begin
                            if (r_ph < PH_HALF) begin
                                w_ph_d = r_ph;
                            end else if (r_ph == PH_MAX) begin
                                w_ph_d = PH_W'(1);
                            end else if (r_ph == PH_MAX - PH_W'(1)) begin
                                w_ph_d = '0;
                            end else begin
                                w_ph_d = r_ph + PH_W'(2);
                            end
                        end
`else
                        w_ph_d = '0;
`endif
                    end
                end else if (w_wrap && (32'(r_silence_cnt) + 32'd1 >= LOSS_BITS)) begin
                    w_state_d = ACQ;
                    w_ok_d    = '0;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_ph_d    = '0;
                w_ok_d    = '0;
                w_sil_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with r_ph. The
    // strobe samples the level ahead of any edge landing in the strobe cycle.
    assign w_strobe_d = (w_state_d != IDLE) && (w_ph_d == PH_HALF);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ph          <= '0;
            r_ok_cnt      <= '0;
            r_silence_cnt <= '0;
            r_level_prev  <= LVL_ZERO;
            r_clk_out     <= 1'b0;
            r_sym_valid   <= 1'b0;
            r_sym         <= LVL_ZERO;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_ph          <= w_ph_d;
            r_ok_cnt      <= w_ok_d;
            r_silence_cnt <= w_sil_d;
            r_level_prev  <= w_level;
            r_clk_out     <= (w_state_d != IDLE) && (w_ph_d >= PH_HALF);
            r_sym_valid   <= w_strobe_d;
            if (w_strobe_d) begin
                r_sym <= w_level;
            end
            r_locked      <= (w_state_d == LOCKED);
        end
    end

    assign clk_out   = r_clk_out;
    assign sym_valid = r_sym_valid;
    assign sym       = r_sym;
    assign locked    = r_locked;

endmodule
